// File: rtl/hilo_div_seq.sv
// Multicycle radix-2 restoring divider for DIV/DIVU in EX: stalls the pipeline while
// iterating, then presents quotient on result_lo and remainder on result_hi with a done strobe.
`timescale 1ns/1ps
module hilo_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr_r;
  logic             neg_q_r;
  logic             neg_r_r;

  logic             dividend_neg_s;
  logic             divisor_neg_s;
  logic [WIDTH-1:0] dividend_abs_s;
  logic [WIDTH-1:0] divisor_abs_s;
  logic             divisor_zero_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quo_next_s;
  logic [WIDTH-1:0] lo_fix_s;
  logic [WIDTH-1:0] hi_fix_s;

  // Two's complement negate, wrapping modulo 2^WIDTH (so -MIN stays MIN).
  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Operand magnitudes and signs captured when a divide is accepted.
  always_comb begin
    dividend_neg_s = signed_div & dividend[WIDTH-1];
    divisor_neg_s  = signed_div & divisor[WIDTH-1];
    dividend_abs_s = dividend;
    divisor_abs_s  = divisor;
    if (dividend_neg_s) begin
      dividend_abs_s = neg2c(dividend);
    end else begin
      dividend_abs_s = dividend;
    end
    if (divisor_neg_s) begin
      divisor_abs_s = neg2c(divisor);
    end else begin
      divisor_abs_s = divisor;
    end
    divisor_zero_s = (divisor == {WIDTH{1'b0}});
  end

  // One restoring step: the shifted partial remainder is WIDTH+1 bits so the borrow is visible.
  always_comb begin
    rem_shift_s = {rem_r, quo_r[WIDTH-1]};
    diff_s      = rem_shift_s - {1'b0, dvsr_r};
    rem_next_s  = rem_shift_s[WIDTH-1:0];
    quo_next_s  = {quo_r[WIDTH-2:0], 1'b0};
    if (diff_s[WIDTH]) begin
      rem_next_s = rem_shift_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
    end else begin
      rem_next_s = diff_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
    end
    lo_fix_s = quo_next_s;
    hi_fix_s = rem_next_s;
    if (neg_q_r) begin
      lo_fix_s = neg2c(quo_next_s);
    end else begin
      lo_fix_s = quo_next_s;
    end
    if (neg_r_r) begin
      hi_fix_s = neg2c(rem_next_s);
    end else begin
      hi_fix_s = rem_next_s;
    end
  end

  // Stall is combinational so the pipeline freezes in the very cycle the divide is accepted.
  always_comb begin
    stall_req = 1'b0;
    if (annul) begin
      stall_req = 1'b0;
    end else begin
      case (state_r)
        IDLE:    stall_req = start;
        ZERO:    stall_req = 1'b1;
        BUSY:    stall_req = 1'b1;
        DONE:    stall_req = 1'b0;
        default: stall_req = 1'b0;
      endcase
    end
  end

  // Sequencer state, datapath registers and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      dvsr_r      <= {WIDTH{1'b0}};
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      done        <= 1'b0;
      result_hi   <= {WIDTH{1'b0}};
      result_lo   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else if (annul) begin
      // Flush: drop the divide but keep the last architected result visible.
      state_r <= IDLE;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvsr_r      <= divisor_abs_s;
            quo_r       <= dividend_abs_s;
            rem_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            neg_q_r     <= dividend_neg_s ^ divisor_neg_s;
            neg_r_r     <= dividend_neg_s;
            div_by_zero <= 1'b0;
            state_r     <= divisor_zero_s ? ZERO : BUSY;
          end
        end
        ZERO: begin
          result_hi   <= {WIDTH{1'b0}};
          result_lo   <= {WIDTH{1'b0}};
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          state_r     <= DONE;
        end
        BUSY: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_CNT) begin
            result_hi <= hi_fix_s;
            result_lo <= lo_fix_s;
            done      <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          if (!start) begin
            done    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
